// File: rtl/result_drain_if.sv
// Bundle of the result-buffer read handshake, output-memory write port and drain status.
// The master side is the drain engine; the slave side is the CNN buffer / host memory.
interface result_drain_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 16
);
   logic                  start;
   logic [CNT_WIDTH-1:0]  expected_count;
   logic [DATA_WIDTH-1:0] result_buffer_out;
   logic                  result_buffer_empty;
   logic                  result_buffer_valid;
   logic                  result_buffer_read_enable;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [CNT_WIDTH-1:0]  received_count;
   logic                  busy;
   logic                  done;
   logic                  overflow;

   modport master (
      input  start, expected_count, result_buffer_out, result_buffer_empty, result_buffer_valid,
      output result_buffer_read_enable, mem_wen, mem_waddr, mem_wdata,
             received_count, busy, done, overflow
   );

   modport slave (
      output start, expected_count, result_buffer_out, result_buffer_empty, result_buffer_valid,
      input  result_buffer_read_enable, mem_wen, mem_waddr, mem_wdata,
             received_count, busy, done, overflow
   );
endinterface

// File: rtl/result_drain.sv
// Drains a programmed number of CNN results, one outstanding read at a time, into a
// local output memory; words beyond the memory depth are consumed and flag overflow.
module result_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 16
) (
   input  logic           clk,
   input  logic           reset,
   result_drain_if.master bus
);
   // The pointer must be able to hold MEM_DEPTH itself so it can saturate there.
   localparam int PTR_W = $clog2(MEM_DEPTH + 1);
   localparam logic [PTR_W-1:0]     DEPTH_P = PTR_W'(MEM_DEPTH);
   localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] expected_q, expected_d;
   logic [CNT_WIDTH-1:0] received_q, received_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic                 overflow_q, overflow_d;
   logic                 rd_en;
   logic                 wen;
   logic [CNT_WIDTH-1:0] received_inc;

   assign received_inc = received_q + CNT_ONE;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      received_d = received_q;
      ptr_d      = ptr_q;
      overflow_d = overflow_q;
      rd_en      = 1'b0;
      wen        = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               expected_d = bus.expected_count;
               received_d = '0;
               ptr_d      = '0;
               overflow_d = 1'b0;
               state_d    = (bus.expected_count == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (!bus.result_buffer_empty) begin
               rd_en   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.result_buffer_valid) begin
               if (ptr_q < DEPTH_P) begin
                  wen   = 1'b1;
                  ptr_d = ptr_q + PTR_ONE;
               end else begin
                  overflow_d = 1'b1;
               end
               received_d = received_inc;
               state_d    = (received_inc == expected_q) ? S_DONE : S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         expected_q <= '0;
         received_q <= '0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         received_q <= received_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Write port is combinational in the valid cycle for zero-latency capture.
   assign bus.result_buffer_read_enable = rd_en;
   assign bus.mem_wen        = wen;
   assign bus.mem_waddr      = ADDR_WIDTH'(ptr_q);
   assign bus.mem_wdata      = wen ? bus.result_buffer_out : '0;
   assign bus.received_count = received_q;
   assign bus.busy           = (state_q == S_REQ) || (state_q == S_WAIT);
   assign bus.done           = (state_q == S_DONE);
   assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: a CNN buffer model feeds words, expected memory
// writes go into a scoreboard queue and an independent monitor checks every write.
module tb_result_drain;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int AW = 3;
   localparam int CW = 16;

   typedef struct {
      int            addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   failed = 0;
   int   rd_total = 0;
   wr_t  exp_q[$];

   always #5 clk = ~clk;

   result_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   result_drain #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every memory write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (bus.result_buffer_read_enable === 1'b1) rd_total++;
      if (bus.mem_wen !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {31'd0, bus.mem_wen}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.mem_waddr), 32'(e.addr));
            check("write_data", 32'(bus.mem_wdata), 32'(e.data));
         end
      end
   end

   task automatic check_all_zero(input string name);
      check(name, {bus.result_buffer_read_enable, bus.mem_wen, bus.mem_waddr, bus.mem_wdata,
                   bus.received_count, bus.busy, bus.done, bus.overflow}, 32'd0);
   endtask

   // One drain of n words. fixed: words 0x11,0x22.. with immediate return and no stalls.
   // stall_after: index before which the buffer stays empty for 10 cycles (-1 none).
   // abort_at: index at which reset is asserted mid-drain (-1 none).
   task automatic run_drain(input int n, input bit fixed, input int stall_after, input int abort_at);
      int            k = 0;
      int            budget = 0;
      int            rd0;
      int            d;
      bit            saw;
      bit            stalled = 0;
      logic [DW-1:0] w;
      rd0 = rd_total;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.expected_count = CW'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.expected_count = CW'($urandom);
      check("done_after_start", {31'd0, bus.done}, 32'(n == 0));
      check("busy_after_start", {31'd0, bus.busy}, 32'(n != 0));
      while (k < n) begin
         if (budget++ > 500) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: got %0d words, expected %0d", k, n);
            break;
         end
         if (abort_at == k) begin
            #2 reset = 1'b0;
            #1 check_all_zero("async_reset_outputs");
            exp_q.delete();
            return;
         end
         if (stall_after == k && !stalled) begin
            stalled = 1;
            bus.result_buffer_empty = 1'b1;
            repeat (10) begin
               @(negedge clk);
               check("stall_no_read", {31'd0, bus.result_buffer_read_enable}, 32'd0);
               check("stall_busy", {31'd0, bus.busy}, 32'd1);
               @(posedge clk); #1;
            end
         end
         bus.result_buffer_empty = fixed ? 1'b0 : ($urandom_range(0, 2) == 0);
         // A valid while requesting must be ignored by the drain.
         bus.result_buffer_valid = !fixed && bus.result_buffer_empty && ($urandom_range(0, 3) == 0);
         bus.result_buffer_out = DW'($urandom);
         @(negedge clk);
         saw = bus.result_buffer_read_enable;
         @(posedge clk); #1;
         bus.result_buffer_valid = 1'b0;
         if (saw) begin
            bus.result_buffer_empty = $urandom_range(0, 1) == 0;
            d = fixed ? 0 : $urandom_range(0, 2);
            repeat (d) begin
               if ($urandom_range(0, 2) == 0) begin
                  bus.start = 1'b1;
                  bus.expected_count = CW'($urandom_range(0, 3));
               end
               @(posedge clk); #1;
               bus.start = 1'b0;
            end
            w = fixed ? DW'(8'h11 * (k + 1)) : DW'($urandom);
            if (k < DEPTH) exp_q.push_back('{addr: k, data: w});
            bus.result_buffer_valid = 1'b1;
            bus.result_buffer_out = w;
            k++;
            @(posedge clk); #1;
            bus.result_buffer_valid = 1'b0;
         end
      end
      check("final_done", {31'd0, bus.done}, 32'd1);
      check("final_busy", {31'd0, bus.busy}, 32'd0);
      check("final_received", 32'(bus.received_count), 32'(n));
      check("final_overflow", {31'd0, bus.overflow}, 32'(n > DEPTH));
      check("final_waddr", 32'(bus.mem_waddr), 32'((n < DEPTH) ? n : DEPTH));
      check("read_pulses", 32'(rd_total - rd0), 32'(n));
      check("writes_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      bus.start = 1'b0;
      bus.expected_count = '0;
      bus.result_buffer_out = '0;
      bus.result_buffer_empty = 1'b1;
      bus.result_buffer_valid = 1'b0;
      #12 check_all_zero("reset_outputs");
      @(posedge clk); #1 reset = 1'b1;

      // Reset mid-drain, then a stray valid in IDLE must not write.
      run_drain(4, 1'b0, -1, 2);
      @(posedge clk); #1 reset = 1'b1;
      bus.result_buffer_valid = 1'b1;
      bus.result_buffer_out = 8'hAA;
      @(posedge clk); #1 bus.result_buffer_valid = 1'b0;
      check("idle_after_reset_received", 32'(bus.received_count), 32'd0);
      check("idle_after_reset_flags", {29'd0, bus.busy, bus.done, bus.overflow}, 32'd0);

      run_drain(3, 1'b1, -1, -1);   // normal 0x11/0x22/0x33
      run_drain(2, 1'b0, 1, -1);    // empty stall after first word
      run_drain(0, 1'b0, -1, -1);   // zero count
      run_drain(6, 1'b0, -1, -1);   // overflow past depth
      run_drain(DEPTH, 1'b0, -1, -1);
      for (int t = 0; t < 20; t++) begin
         run_drain($urandom_range(0, 9), 1'b0, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Host-side reader for the CNN result buffer: the CNN writes results, this block reads them out.
- Reads convolution results through the read-enable/valid/empty handshake and writes each word into a local output memory at consecutive addresses.
- Counts results against a programmed expected total and flags completion and memory overflow.
- Sits between the CNN top and the testbench/host memory.

Parameters:
- DATA_WIDTH, 8, width of one result word (matches RESULT_BUFFER_WIDTH)
- MEM_DEPTH, 64, number of words in the output memory
- ADDR_WIDTH, 6, output memory address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH
- CNT_WIDTH, 16, width of the expected/received result counters

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches expected_count and begins draining
- expected_count  in  CNT_WIDTH  number of results to drain; sampled only on accepted start
- result_buffer_out  in  DATA_WIDTH  result word from CNN
- result_buffer_empty  in  1  CNN result buffer holds no words
- result_buffer_valid  in  1  result_buffer_out carries a word returned for a prior read
- result_buffer_read_enable  out  1  one-cycle read request to CNN result buffer
- mem_wen  out  1  output memory write strobe
- mem_waddr  out  ADDR_WIDTH  output memory write address
- mem_wdata  out  DATA_WIDTH  output memory write data
- received_count  out  CNT_WIDTH  results consumed since last start
- busy  out  1  high in REQ and WAIT
- done  out  1  level; high in DONE
- overflow  out  1  sticky; set when a result arrives with the memory already full

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - Outputs: result_buffer_read_enable=0, mem_wen=0, mem_waddr=0, mem_wdata=0, received_count=0, busy=0, done=0, overflow=0.
  - Internal expected register=0.
  - Reset mid-operation aborts immediately; a valid arriving after reset deasserts is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start: latch expected_count, clear received_count, mem_waddr and overflow.
  - If expected_count==0, go to DONE; otherwise go to REQ.
- REQ:
  - If result_buffer_empty==0: result_buffer_read_enable=1 for exactly this cycle, then go to WAIT.
  - Else stay in REQ with read_enable=0.
  - A result_buffer_valid seen in REQ is ignored (no write, no count).
- WAIT:
  - At most one read outstanding. Hold until result_buffer_valid==1; no timeout.
  - On valid, in the same cycle:
    - If the write pointer < MEM_DEPTH: mem_wen=1, mem_wdata=result_buffer_out, mem_waddr=pointer; pointer increments in the next cycle.
    - Otherwise: mem_wen=0 and overflow is set; the word is consumed and discarded.
    - received_count increments in both cases.
  - If received_count+1==expected, go to DONE; else go to REQ.
- Write path timing:
  - mem_wen, mem_waddr and mem_wdata are combinational in the valid cycle (zero latency); mem_wen=0 in all other cycles.
  - The pointer saturates at MEM_DEPTH and does not wrap.
- DONE:
  - done=1. received_count and overflow hold.
  - start restarts exactly as from IDLE; done drops the cycle after start is accepted.
- start while busy is ignored (no re-latch, no counter change).
- Throughput: one word per two cycles minimum (REQ, WAIT with valid returned the next cycle).
- Width rules:
  - received_count compares at CNT_WIDTH.
  - expected_count of up to 2^CNT_WIDTH-1 is legal; counting beyond MEM_DEPTH produces overflow, not wrap.

Test Plan:
- Reset mid-drain: start with expected=4; assert reset low after 2 words -> every output returns to 0 asynchronously, state=IDLE; a later valid pulse produces no write.
- Normal drain: expected=3, buffer holds words 0x11, 0x22, 0x33 with valid returned one cycle after read_enable -> mem writes addr0=0x11, addr1=0x22, addr2=0x33; done=1; received_count=3; overflow=0; exactly 3 read_enable pulses.
- Empty stall: expected=2; empty=1 for 10 cycles after the first word -> read_enable stays 0 throughout, busy=1; resumes once empty=0; done only after the 2nd word.
- Zero count: start with expected=0 -> DONE the next cycle; no read_enable and no mem_wen.
- Overflow: MEM_DEPTH=4, expected=6 -> addr0..3 written; words 5 and 6 are consumed without a write; overflow=1; received_count=6; done=1; mem_waddr stays 4.
- Spurious events: valid pulsed while in REQ, and start pulsed while in WAIT -> no write, no count change, expected register unchanged.
